avalon_st_pkt_buffer: RTL and testbench
=======================================

// Module: avalon_st_pkt_buffer
// PURPOSE
//  Store-and-forward packet buffer for the loopback path. The sink side implements the
//  avalon_st_if slave modport and accepts beats from an upstream master. The source side
//  re-drives whole packets as an avalon_st_if master. A packet is presented downstream only
//  after its eop beat is stored. Malformed and oversize packets are discarded and counted.
// PARAMETERS
//  DATA_WIDTH  32  data bus width; EMPTY_W = $clog2(DATA_WIDTH) sets the empty field width
//  DEPTH       64  beat storage entries (power of 2, >=4); PTR_W = $clog2(DEPTH)
//  CNT_W       16  width of status counters
// PORTS
//  clk        in   1            single clock; all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  in_vld     in   1            sink: beat valid
//  in_rdy     out  1            sink: buffer can take beat
//  in_sop     in   1            sink: start of packet
//  in_eop     in   1            sink: end of packet
//  in_data    in   DATA_WIDTH   sink: payload
//  in_empty   in   EMPTY_W      sink: unused symbols, meaningful on eop only
//  out_vld    out  1            source: beat valid
//  out_rdy    in   1            source: downstream ready
//  out_sop    out  1            source: start of packet
//  out_eop    out  1            source: end of packet
//  out_data   out  DATA_WIDTH   source: payload
//  out_empty  out  EMPTY_W      source: unused symbols; 0 on non-eop beats
//  pkt_cnt    out  PTR_W+1      complete packets stored and not yet fully read
//  drop_cnt   out  CNT_W        packets discarded; saturates at all-ones
// BEHAVIOUR
//  - Beat transfer occurs on a cycle with vld&&rdy, on either side. The sink may drop in_vld
//    without waiting for in_rdy. The source holds out_* stable while out_vld&&!out_rdy.
//  - Reset: wr_ptr=rd_ptr=pkt_start=0, used=0, pkt_cnt=0, drop_cnt=0, sink FSM=IDLE.
//    Outputs: in_rdy=0, out_vld=0, out_sop=0, out_eop=0, out_data=0, out_empty=0.
//    in_rdy rises the cycle after rst deasserts. Reset mid-packet discards all stored data.
//  - Each entry stores {sop,eop,empty,data}. used = written entries (committed + in-progress).
//  - in_rdy = !rst_q && (state==DISCARD || used<DEPTH).
//  - Sink FSM:
//     IDLE:    accepted sop beat -> write entry, pkt_start=wr_ptr.
//              If eop is also set, the packet commits and the FSM stays IDLE; else -> IN_PKT.
//              Accepted beat without sop -> not written, drop_cnt++, stay IDLE.
//     IN_PKT:  accepted beat without sop -> write entry; eop -> commit, -> IDLE.
//              Accepted beat with sop -> abandon the partial packet: wr_ptr rewinds to
//              pkt_start and used is reduced by its length, drop_cnt++.
//              The new beat is written as a fresh packet start in the same cycle.
//              If that beat also has eop, it commits and the FSM goes to IDLE.
//              Otherwise the FSM stays IN_PKT.
//              used==DEPTH && pkt_cnt==0 (oversize) -> rewind to pkt_start, drop_cnt++, -> DISCARD.
//     DISCARD: in_rdy=1; all beats dropped; accepted eop -> IDLE.
//              Accepted sop (without eop) -> treated as an IDLE sop, and the old packet is not
//              counted again.
//  - Commit: pkt_cnt increments on the cycle the eop beat is written. out_vld may assert on
//    the next cycle, so min sink-eop to source-valid latency = 1 clk.
//  - Source: out_vld=1 iff pkt_cnt>0 (head entry belongs to a committed packet).
//    out_* shows the head entry; each accepted beat advances rd_ptr and decrements used.
//    An accepted eop beat decrements pkt_cnt. A simultaneous commit and eop read leaves
//    pkt_cnt unchanged. A simultaneous write and read leaves used unchanged.
//  - Pointers wrap modulo DEPTH. Full (used==DEPTH) and empty (used==0) are distinguished by
//    used, never by pointer equality.
//  - out_empty is forced to 0 when out_eop=0. in_empty is ignored on non-eop beats.
//  - Throughput: 1 beat/clk on each side concurrently; no bubbles between back-to-back packets.
// TESTING
//  1. 3-beat pkt (sop d=0xA0, 0xA1, eop d=0xA2 empty=2), out_rdy=1 -> out_vld rises 1 clk
//     after the eop write; 3 beats out identical, then pkt_cnt=0 and drop_cnt=0.
//  2. Single-beat pkt (sop&eop, empty=3) while out_rdy=0 for 10 clk -> out_vld=1 held stable
//     with pkt_cnt=1; release out_rdy -> one beat out, pkt_cnt=0.
//  3. 2 beats then a new sop pkt of 2 beats -> first pkt is never output, drop_cnt=1, and only
//     the second pkt appears downstream.
//  4. Non-sop beat in IDLE -> in_rdy=1, beat dropped, drop_cnt=1, out_vld stays 0.
//  5. DEPTH=64, out_rdy=0, 70-beat pkt -> at beat 64 enters DISCARD, remaining beats accepted;
//     after eop drop_cnt=1, pkt_cnt=0, used=0; a following 2-beat pkt passes intact.
//  6. Stream 20 random-length pkts with random out_rdy, then assert rst mid-packet for 1 clk ->
//     all pre-reset pkts match the scoreboard; after reset out_vld=0, pkt_cnt=0, drop_cnt=0.

Source files
------------

// File: rtl/avalon_st_pkt_buffer.sv
// Store-and-forward Avalon-ST packet buffer: a packet becomes visible downstream only once
// its eop beat is stored; malformed or oversize packets are discarded and counted.
module avalon_st_pkt_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int CNT_W      = 16,
   localparam int EMPTY_W   = $clog2(DATA_WIDTH),
   localparam int PTR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [EMPTY_W-1:0]    in_empty,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [EMPTY_W-1:0]    out_empty,
   output logic [PTR_W:0]        pkt_cnt,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam int ENT_W = DATA_WIDTH + EMPTY_W + 2;
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;
   state_t state, state_nxt;

   logic [ENT_W-1:0]      mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt, rd_ptr, pkt_start, pkt_start_nxt, wr_addr;
   logic [PTR_W:0]        used, cur_len, cur_len_nxt, rewind_len;
   logic                  rst_q, wr_en, commit, drop, acc, rd;
   logic                  head_sop, head_eop;
   logic [EMPTY_W-1:0]    head_empty, wr_empty;
   logic [DATA_WIDTH-1:0] head_data;

   // DISCARD keeps the sink flowing so an oversize packet can be swallowed to its eop.
   assign in_rdy = !rst && !rst_q && (state == DISCARD || used < FULL);
   assign acc    = in_vld && in_rdy;

   assign {head_sop, head_eop, head_empty, head_data} = mem[rd_ptr];
   assign out_vld   = (pkt_cnt != '0);
   assign out_sop   = out_vld && head_sop;
   assign out_eop   = out_vld && head_eop;
   assign out_empty = out_eop ? head_empty : '0;
   assign out_data  = out_vld ? head_data : '0;
   assign rd        = out_vld && out_rdy;

   assign wr_empty = in_eop ? in_empty : '0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= {in_sop, in_eop, wr_empty, in_data};
   end

   always_comb begin
      state_nxt     = state;
      wr_en         = 1'b0;
      wr_addr       = wr_ptr;
      wr_ptr_nxt    = wr_ptr;
      pkt_start_nxt = pkt_start;
      cur_len_nxt   = cur_len;
      rewind_len    = '0;
      commit        = 1'b0;
      drop          = 1'b0;
      case (state)
         IDLE, DISCARD: begin
            if (acc && state == DISCARD && in_eop) begin
               state_nxt = IDLE;
            end else if (acc && in_sop) begin
               wr_en         = 1'b1;
               pkt_start_nxt = wr_ptr;
               wr_ptr_nxt    = wr_ptr + PTR_W'(1);
               if (in_eop) begin
                  commit      = 1'b1;
                  cur_len_nxt = '0;
                  state_nxt   = IDLE;
               end else begin
                  cur_len_nxt = (PTR_W+1)'(1);
                  state_nxt   = IN_PKT;
               end
            end else if (acc && state == IDLE) begin
               drop = 1'b1;
            end
         end
         IN_PKT: begin
            // Storage is full of one unfinished packet: nothing can drain, so give it up.
            if (used == FULL && pkt_cnt == '0) begin
               rewind_len  = cur_len;
               wr_ptr_nxt  = pkt_start;
               cur_len_nxt = '0;
               drop        = 1'b1;
               state_nxt   = DISCARD;
            end else if (acc) begin
               wr_en = 1'b1;
               if (in_sop) begin
                  rewind_len = cur_len;
                  drop       = 1'b1;
                  wr_addr    = pkt_start;
                  wr_ptr_nxt = pkt_start + PTR_W'(1);
               end else begin
                  wr_ptr_nxt = wr_ptr + PTR_W'(1);
               end
               if (in_eop) begin
                  commit      = 1'b1;
                  cur_len_nxt = '0;
                  state_nxt   = IDLE;
               end else begin
                  cur_len_nxt = (in_sop ? '0 : cur_len) + (PTR_W+1)'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pkt_start <= '0;
         used      <= '0;
         cur_len   <= '0;
         pkt_cnt   <= '0;
         drop_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         pkt_start <= pkt_start_nxt;
         cur_len   <= cur_len_nxt;
         used      <= used - rewind_len + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd);
         pkt_cnt   <= pkt_cnt + (PTR_W+1)'(commit) - (PTR_W+1)'(rd && head_eop);
         if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_avalon_st_pkt_buffer.sv
// Directed and random bench for avalon_st_pkt_buffer; expected beats are queued when a
// well-formed packet is sent and popped as the source side hands beats out.
module tb_avalon_st_pkt_buffer;

   localparam int DW = 32;
   localparam int EW = 5;
   localparam int PW = 6;
   localparam int CW = 16;
   localparam int BW = DW + EW + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_vld = 1'b0;
   logic          in_rdy;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [EW-1:0] in_empty = '0;
   logic          out_vld;
   logic          out_rdy = 1'b0;
   logic          out_sop;
   logic          out_eop;
   logic [DW-1:0] out_data;
   logic [EW-1:0] out_empty;
   logic [PW:0]   pkt_cnt;
   logic [CW-1:0] drop_cnt;

   logic [BW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;
   bit            rand_rdy = 1'b0;
   logic          vld_at_acc;
   int            pkt_waits = 0;

   always #5 clk = ~clk;

   avalon_st_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(64), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_sop(in_sop), .in_eop(in_eop),
      .in_data(in_data), .in_empty(in_empty),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_sop(out_sop), .out_eop(out_eop),
      .out_data(out_data), .out_empty(out_empty),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: a beat seen with out_vld && out_rdy at negedge transfers on the next posedge.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_vld === 1'b1 && out_rdy === 1'b1) begin
         chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("out_beat", {out_sop, out_eop, out_empty, out_data}, exp_q.pop_front());
      end
   end

   // All driver tasks start and end at posedge + 1.
   task automatic send_beat(input logic sop, input logic eop, input logic [EW-1:0] emp,
                            input logic [DW-1:0] d, output bit acc);
      int w;
      w = 0;
      acc = 1'b0;
      in_vld = 1'b1; in_sop = sop; in_eop = eop; in_empty = emp; in_data = d;
      while (!acc && w < 200) begin
         @(negedge clk);
         if (in_rdy === 1'b1) begin
            acc = 1'b1;
            vld_at_acc = out_vld;
         end
         @(posedge clk); #1;
         if (!acc) w++;
         if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
      end
      pkt_waits += w;
      chk("beat_accepted", 64'(acc), 64'd1);
      in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic send_pkt(input int len, input logic [DW-1:0] base, input bit with_eop,
                           input bit push, input logic [EW-1:0] emp);
      logic [BW-1:0] pend[$];
      bit acc;
      for (int i = 0; i < len; i++) begin
         logic s, e;
         logic [EW-1:0] em_drv, em_exp;
         s = (i == 0);
         e = with_eop && (i == len - 1);
         em_drv = e ? emp : EW'($urandom_range(1, 31));
         em_exp = e ? emp : '0;
         send_beat(s, e, em_drv, base + DW'(i), acc);
         pend.push_back({s, e, em_exp, base + DW'(i)});
      end
      if (push) foreach (pend[k]) exp_q.push_back(pend[k]);
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(posedge clk); #1;
         if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; rand_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
   endtask

   initial begin
      bit acc;
      // Reset state
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_out_flags", {out_sop, out_eop, out_empty}, 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst_low", 64'(in_rdy), 64'd0);
      @(posedge clk); #1;

      // 1: 3-beat packet, out_vld one clock after eop write
      out_rdy = 1'b1;
      send_pkt(3, 32'hA0, 1'b1, 1'b1, 5'd2);
      chk("t1_vld_at_eop", 64'(vld_at_acc), 64'd0);
      @(negedge clk);
      chk("t1_vld_next", 64'(out_vld), 64'd1);
      @(posedge clk); #1;
      wait_drain(50);
      @(negedge clk);
      chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #1;

      // 2: single-beat packet held under backpressure
      out_rdy = 1'b0;
      send_pkt(1, 32'hB0, 1'b1, 1'b1, 5'd3);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t2_hold_vld", 64'(out_vld), 64'd1);
         chk("t2_hold_beat", {out_sop, out_eop, out_empty, out_data}, {1'b1, 1'b1, 5'd3, 32'hB0});
         chk("t2_hold_cnt", 64'(pkt_cnt), 64'd1);
         @(posedge clk); #1;
      end
      out_rdy = 1'b1;
      wait_drain(50);
      @(negedge clk);
      chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd0);
      @(posedge clk); #1;

      // 3: partial packet abandoned by a new sop
      do_reset();
      out_rdy = 1'b1;
      send_pkt(2, 32'hC0, 1'b0, 1'b0, 5'd0);
      send_pkt(2, 32'hD0, 1'b1, 1'b1, 5'd1);
      wait_drain(50);
      @(negedge clk);
      chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
      chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd0);
      @(posedge clk); #1;

      // 4: non-sop beat in IDLE is swallowed and counted
      do_reset();
      out_rdy = 1'b1;
      pkt_waits = 0;
      send_beat(1'b0, 1'b0, 5'd0, 32'hF0, acc);
      chk("t4_no_stall", 64'(pkt_waits), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_out_vld", 64'(out_vld), 64'd0);
         @(posedge clk); #1;
      end
      chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);

      // 5: oversize packet goes to DISCARD after filling storage
      do_reset();
      out_rdy = 1'b0;
      pkt_waits = 0;
      send_pkt(70, 32'h1000, 1'b1, 1'b0, 5'd0);
      chk("t5_one_stall", 64'(pkt_waits), 64'd1);
      @(negedge clk);
      chk("t5_drop_cnt", 64'(drop_cnt), 64'd1);
      chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("t5_out_vld", 64'(out_vld), 64'd0);
      @(posedge clk); #1;
      out_rdy = 1'b1;
      send_pkt(2, 32'h2000, 1'b1, 1'b1, 5'd7);
      wait_drain(50);
      @(negedge clk);
      chk("t5_after_cnt", 64'(pkt_cnt), 64'd0);
      chk("t5_after_drop", 64'(drop_cnt), 64'd1);
      @(posedge clk); #1;

      // 6: random traffic, then reset in the middle of a packet
      do_reset();
      rand_rdy = 1'b1;
      for (int p = 0; p < 20; p++) begin
         send_pkt($urandom_range(1, 8), DW'($urandom), 1'b1, 1'b1, EW'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            out_rdy = 1'($urandom_range(0, 1));
         end
      end
      wait_drain(3000);
      @(negedge clk);
      chk("t6_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #1;
      rand_rdy = 1'b0;
      out_rdy = 1'b1;
      send_pkt(3, 32'hE0, 1'b0, 1'b0, 5'd0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_out_vld", 64'(out_vld), 64'd0);
      chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("t6_drop_cnt_rst", 64'(drop_cnt), 64'd0);
      chk("t6_in_rdy_low", 64'(in_rdy), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_in_rdy_high", 64'(in_rdy), 64'd1);
      @(posedge clk); #1;
      send_pkt(3, 32'h3000, 1'b1, 1'b1, 5'd4);
      wait_drain(50);
      @(negedge clk);
      chk("t6_final_cnt", 64'(pkt_cnt), 64'd0);
      chk("t6_final_drop", 64'(drop_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
